// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use and redirect hazard control.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [15:0]     id_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            branch_decision,
    input  logic            ex_hold,
    output logic            ex_valid,
    output logic [15:0]     ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            pc_src,
    output logic            stall_f,
    output logic            stall_d,
`ifdef ID_EX_PERF_EN
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_flushes,
`endif
    output logic            flush_d
);

    typedef struct packed {
        logic            valid;
        logic [15:0]     ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } id_ex_t;

    id_ex_t ex_d, ex_q, id_pkt;
    logic   load_use, redirect;

    always_comb begin
        id_pkt.valid = id_valid;
        id_pkt.ctrl  = id_ctrl & 16'hFFFE;
        id_pkt.pc    = id_pc;
        id_pkt.rd1   = id_rd1;
        id_pkt.rd2   = id_rd2;
        id_pkt.imm   = id_imm;
        id_pkt.rs1   = id_rs1;
        id_pkt.rs2   = id_rs2;
        id_pkt.rd    = id_rd;
    end

    assign load_use = ex_q.valid & ex_q.ctrl[1]
                    & (ex_q.rd != 5'd0) & id_valid
                    & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    assign redirect = ex_q.valid
                    & ((ex_q.ctrl[12] & branch_decision) | ex_q.ctrl[11]);

    // Redirect beats load_use: the stalled ID instruction is wrong-path anyway.
    always_comb begin
        ex_d    = ex_q;
        pc_src  = 1'b0;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        if (reset) begin
            ex_d = '0;
        end else if (ex_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (redirect) begin
            pc_src  = 1'b1;
            flush_d = 1'b1;
            ex_d    = '0;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            ex_d    = '0;
        end else begin
            ex_d = id_valid ? id_pkt : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_valid = ex_q.valid;
    assign ex_ctrl  = ex_q.ctrl;
    assign ex_pc    = ex_q.pc;
    assign ex_rd1   = ex_q.rd1;
    assign ex_rd2   = ex_q.rd2;
    assign ex_imm   = ex_q.imm;
    assign ex_rs1   = ex_q.rs1;
    assign ex_rs2   = ex_q.rs2;
    assign ex_rd    = ex_q.rd;

`ifdef ID_EX_PERF_EN
    logic [31:0] bub_d, bub_q, fl_d, fl_q;

    always_comb begin
        bub_d = bub_q;
        fl_d  = fl_q;
        if (!ex_hold && redirect && fl_q != '1)
            fl_d = fl_q + 32'd1;
        if (!ex_hold && load_use && bub_q != '1)
            bub_d = bub_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bub_q <= '0;
            fl_q  <= '0;
        end else begin
            bub_q <= bub_d;
            fl_q  <= fl_d;
        end
    end

    assign perf_bubbles = bub_q;
    assign perf_flushes = fl_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed plan plus random traffic against a cycle model.
// Define ID_EX_PERF_EN to also check the performance counters.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset, id_valid, branch_decision, ex_hold;
    logic [15:0] id_ctrl, ex_ctrl;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
    logic        ex_valid, pc_src, stall_f, stall_d, flush_d;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles, perf_flushes;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_decision(branch_decision),
        .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .pc_src(pc_src), .stall_f(stall_f),
        .stall_d(stall_d),
`ifdef ID_EX_PERF_EN
        .perf_bubbles(perf_bubbles),
        .perf_flushes(perf_flushes),
`endif
        .flush_d(flush_d)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    // Model of what EX should hold: a real instruction or nothing.
    logic        m_valid;
    logic [15:0] m_ctrl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_bub, m_fl;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_valid = 0; m_ctrl = 0; m_pc = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [15:0] c,
                        input logic [31:0] pc,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] im,
                        input logic [4:0] s1,
                        input logic [4:0] s2,
                        input logic [4:0] d,
                        input logic bd, input logic h);
        logic lu, rdr, e_src, e_stall;
        @(negedge clk);
        reset = r; id_valid = v; id_ctrl = c;
        id_pc = pc; id_rd1 = a; id_rd2 = b; id_imm = im;
        id_rs1 = s1; id_rs2 = s2; id_rd = d;
        branch_decision = bd; ex_hold = h;
        #1;
        lu  = m_valid && m_ctrl[1] && m_rd != 0 && v
              && (m_rd == s1 || m_rd == s2);
        rdr = m_valid && ((m_ctrl[12] && bd) || m_ctrl[11]);
        e_src   = !r && !h && rdr;
        e_stall = !r && (h || (!rdr && lu));
        if (armed) begin
            check("ex_valid", 64'(ex_valid), 64'(m_valid));
            check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            check("ex_pc", 64'(ex_pc), 64'(m_pc));
            check("ex_rd1", 64'(ex_rd1), 64'(m_rd1));
            check("ex_rd2", 64'(ex_rd2), 64'(m_rd2));
            check("ex_imm", 64'(ex_imm), 64'(m_imm));
            check("ex_regs", 64'({ex_rs1, ex_rs2, ex_rd}),
                  64'({m_rs1, m_rs2, m_rd}));
            check("pc_src", 64'(pc_src), 64'(e_src));
            check("flush_d", 64'(flush_d), 64'(e_src));
            check("stall_f", 64'(stall_f), 64'(e_stall));
            check("stall_d", 64'(stall_d), 64'(e_stall));
`ifdef ID_EX_PERF_EN
            check("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
            check("perf_flushes", 64'(perf_flushes), 64'(m_fl));
`endif
        end
        @(posedge clk);
        if (r) begin
            m_clear();
            m_bub = 0;
            m_fl  = 0;
            armed = 1;
        end else if (h) begin
            // EX frozen
        end else if (rdr) begin
            m_clear();
            if (m_fl != 32'hFFFFFFFF) m_fl++;
        end else if (lu) begin
            m_clear();
            if (m_bub != 32'hFFFFFFFF) m_bub++;
        end else if (v) begin
            m_valid = 1; m_ctrl = c & 16'hFFFE;
            m_pc = pc; m_rd1 = a; m_rd2 = b; m_imm = im;
            m_rs1 = s1; m_rs2 = s2; m_rd = d;
        end else begin
            m_clear();
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] r32;
        logic [15:0] c;
        m_clear();
        m_bub = 0;
        m_fl  = 0;
        // reset with live-looking ID contents
        step(1, 1, 16'hFFFE, 1, 2, 3, 4, 1, 2, 3, 1, 0);
        step(1, 1, 16'hFFFE, 1, 2, 3, 4, 1, 2, 3, 1, 0);
        // pass-through
        step(0, 1, 16'h0106, 32'h100, 11, 22, 33, 1, 2, 5, 0, 0);
        idle();
        // load-use on rs2, then retry
        step(0, 1, 16'h0102, 32'h200, 0, 0, 4, 1, 2, 7, 0, 0);
        step(0, 1, 16'h0100, 32'h204, 0, 0, 0, 3, 7, 8, 0, 0);
        step(0, 1, 16'h0100, 32'h204, 0, 0, 0, 3, 7, 8, 0, 0);
        idle();
        // taken and not-taken branch
        step(0, 1, 16'h1000, 32'h300, 0, 0, 16, 1, 2, 0, 0, 0);
        step(0, 1, 16'h0100, 32'h304, 0, 0, 0, 1, 2, 3, 1, 0);
        step(0, 1, 16'h1000, 32'h308, 0, 0, 16, 1, 2, 0, 0, 0);
        step(0, 1, 16'h0100, 32'h30C, 0, 0, 0, 1, 2, 3, 0, 0);
        idle();
        // jump that also looks like a load producer of x9
        step(0, 1, 16'h0902, 32'h400, 0, 0, 8, 0, 0, 9, 0, 0);
        step(0, 1, 16'h0100, 32'h404, 0, 0, 0, 9, 0, 4, 0, 0);
        idle();
        // hold with jump in EX
        step(0, 1, 16'h0900, 32'h500, 0, 0, 8, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 16'h0100, 32'h504, 0, 0, 0, 2, 3, 4, 0, 1);
        step(0, 1, 16'h0100, 32'h504, 0, 0, 0, 2, 3, 4, 0, 0);
        idle();
        // random traffic with a small register space for frequent hazards
        for (int i = 0; i < 3000; i++) begin
            r32 = $urandom;
            c = r32[15:0] & 16'hE7FD;
            if ($urandom_range(0, 9) < 4) c[1] = 1'b1;
            if ($urandom_range(0, 9) < 3) c[12] = 1'b1;
            if ($urandom_range(0, 19) < 3) c[11] = 1'b1;
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 9) < 8, c,
                 $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 2);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
